ellipse_cmd_scheduler: RTL and testbench

Front-end controller for ellipse_drawer. It accepts ellipse draw commands from two requesters (r0 = host port, r1 = sprite/overlay engine) and arbitrates them round-robin into a small command FIFO. It then issues each command to the single ellipse_drawer, waiting for completion before issuing the next. Each retired command is reported with its source and a status code: ok, degenerate-skipped or timeout.

---
 rtl/ellipse_cmd_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_ellipse_cmd_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ellipse_cmd_scheduler.sv
// Round-robin front end for ellipse_drawer: two requesters feed a small command
// FIFO, and one command at a time is issued to the drawer and retired with a status.
module ellipse_cmd_scheduler #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 65536,
  parameter int unsigned CW      = 10
) (
  input  logic                         clk,
  input  logic                         rst_,
  input  logic                         r0_valid,
  output logic                         r0_ready,
  input  logic [4*CW-1:0]              r0_cmd,
  input  logic                         r1_valid,
  output logic                         r1_ready,
  input  logic [4*CW-1:0]              r1_cmd,
  output logic [4*CW-1:0]              drw_cmd,
  output logic                         drw_start,
  input  logic                         drw_done,
  output logic                         cmp_valid,
  output logic                         cmp_src,
  output logic [1:0]                   cmp_err,
  output logic                         busy,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = $clog2(DEPTH+1);
  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam int unsigned EW = 4*CW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_WAIT,
    S_REPORT
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;

  logic [EW-1:0]    r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LW-1:0]    r_count;
  logic             r_pref1;
  logic [4*CW-1:0]  r_drw_cmd;
  logic             r_src;
  logic [1:0]       r_err;
  logic [TW-1:0]    r_cnt;

  logic             w_full;
  logic             w_empty;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_push;
  logic             w_pop;
  logic [EW-1:0]    w_wdata;
  logic [EW-1:0]    w_rdata;
  logic             w_degen;
  logic             w_timeout;
  logic             w_start;
  logic             w_err_load;
  logic [1:0]       w_err_nxt;

  // Arbitration: a lone requester always wins; on contention the rr pointer decides.
  assign w_full   = (r_count == LW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_grant0 = r0_valid & (~r1_valid | ~r_pref1);
  assign w_grant1 = r1_valid & (~r0_valid |  r_pref1);
  assign r0_ready = w_grant0 & ~w_full & ~rst_;
  assign r1_ready = w_grant1 & ~w_full & ~rst_;
  assign w_push   = (r0_valid & r0_ready) | (r1_valid & r1_ready);
  assign w_wdata  = r1_ready ? {1'b1, r1_cmd} : {1'b0, r0_cmd};

  // Pop decision uses registered occupancy, so a fresh push is never popped same cycle.
  assign w_pop    = (r_state == S_IDLE) & ~w_empty;
  assign w_rdata  = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_pref1 <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr  <= r_wptr + AW'(1);
        r_pref1 <= r0_ready;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push & ~w_pop) begin
        r_count <= r_count + LW'(1);
      end else if (~w_push & w_pop) begin
        r_count <= r_count - LW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= w_wdata;
    end
  end

  assign w_degen   = (r_drw_cmd[2*CW-1:CW] == '0) | (r_drw_cmd[CW-1:0] == '0);
  assign w_timeout = (r_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_err_load  = 1'b0;
    w_err_nxt   = r_err;
    case (r_state)
      S_IDLE: begin
        if (~w_empty) begin
          w_state_nxt = S_CHECK;
        end
      end
      S_CHECK: begin
        if (w_degen) begin
          w_err_load  = 1'b1;
          w_err_nxt   = 2'b01;
          w_state_nxt = S_REPORT;
        end else begin
          w_start     = 1'b1;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (drw_done) begin
          w_err_load  = 1'b1;
          w_err_nxt   = 2'b00;
          w_state_nxt = S_REPORT;
        end else if (w_timeout) begin
          w_err_load  = 1'b1;
          w_err_nxt   = 2'b10;
          w_state_nxt = S_REPORT;
        end
      end
      S_REPORT: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_) begin
      r_drw_cmd <= '0;
      r_src     <= 1'b0;
      r_err     <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_pop) begin
        {r_src, r_drw_cmd} <= w_rdata;
      end
      if (w_err_load) begin
        r_err <= w_err_nxt;
      end
      if (r_state == S_CHECK) begin
        r_cnt <= '0;
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt + TW'(1);
      end
    end
  end

  // Strobes are gated by reset so nothing escapes on the edge that resets the FSM.
  assign drw_cmd    = r_drw_cmd;
  assign drw_start  = w_start & ~rst_;
  assign cmp_valid  = (r_state == S_REPORT) & ~rst_;
  assign cmp_src    = cmp_valid & r_src;
  assign cmp_err    = cmp_valid ? r_err : 2'b00;
  assign busy       = ((r_state != S_IDLE) | ~w_empty) & ~rst_;
  assign fifo_level = r_count;

endmodule

// File: tb/tb_ellipse_cmd_scheduler.sv
// Directed bench for ellipse_cmd_scheduler: arbitration, FIFO backpressure,
// degenerate/timeout statuses and reset in mid-operation.
module tb_ellipse_cmd_scheduler;

  localparam int unsigned CW      = 10;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned LW      = $clog2(DEPTH+1);

  logic            clk = 1'b0;
  logic            rst_ = 1'b1;
  logic            r0_valid = 1'b0;
  logic            r0_ready;
  logic [4*CW-1:0] r0_cmd = '0;
  logic            r1_valid = 1'b0;
  logic            r1_ready;
  logic [4*CW-1:0] r1_cmd = '0;
  logic [4*CW-1:0] drw_cmd;
  logic            drw_start;
  logic            drw_done = 1'b0;
  logic            cmp_valid;
  logic            cmp_src;
  logic [1:0]      cmp_err;
  logic            busy;
  logic [LW-1:0]   fifo_level;

  int nassert = 0;
  int nfail   = 0;

  ellipse_cmd_scheduler #(
    .DEPTH   (DEPTH),
    .TIMEOUT (TIMEOUT),
    .CW      (CW)
  ) dut (
    .clk        (clk),
    .rst_       (rst_),
    .r0_valid   (r0_valid),
    .r0_ready   (r0_ready),
    .r0_cmd     (r0_cmd),
    .r1_valid   (r1_valid),
    .r1_ready   (r1_ready),
    .r1_cmd     (r1_cmd),
    .drw_cmd    (drw_cmd),
    .drw_start  (drw_start),
    .drw_done   (drw_done),
    .cmp_valid  (cmp_valid),
    .cmp_src    (cmp_src),
    .cmp_err    (cmp_err),
    .busy       (busy),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  function automatic logic [4*CW-1:0] mk(input int x, input int y, input int a, input int b);
    return {10'(x), 10'(y), 10'(a), 10'(b)};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nassert++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_ = 1'b1;
    r0_valid = 1'b0;
    r1_valid = 1'b0;
    drw_done = 1'b0;
    cyc();
    cyc();
    rst_ = 1'b0;
  endtask

  task automatic wait_start(input string tag);
    int n = 0;
    while (drw_start !== 1'b1 && n < 40) begin
      cyc();
      n++;
    end
    chk(tag, drw_start, 1);
  endtask

  // Issue-to-retire for a normally completing command: done one cycle into WAIT.
  task automatic run_cmd(input string tag, input logic [4*CW-1:0] exp_cmd, input logic exp_src);
    wait_start({tag, "_start"});
    chk({tag, "_cmd"}, drw_cmd, exp_cmd);
    cyc();
    drw_done = 1'b1;
    @(posedge clk);
    #1 drw_done = 1'b0;
    #1;
    chk({tag, "_cmpv"}, cmp_valid, 1);
    chk({tag, "_src"}, cmp_src, exp_src);
    chk({tag, "_err"}, cmp_err, 2'b00);
  endtask

  logic [4*CW-1:0] bq [5];

  initial begin
    // Reset state with all inputs asserted
    rst_ = 1'b1; r0_valid = 1'b1; r1_valid = 1'b1; drw_done = 1'b1;
    cyc(); cyc();
    chk("rst_r0_ready", r0_ready, 0);
    chk("rst_r1_ready", r1_ready, 0);
    chk("rst_start", drw_start, 0);
    chk("rst_cmpv", cmp_valid, 0);
    chk("rst_cmperr", cmp_err, 0);
    chk("rst_busy", busy, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_drwcmd", drw_cmd, 0);
    r0_valid = 1'b0; r1_valid = 1'b0; drw_done = 1'b0;
    rst_ = 1'b0;

    // Single command
    r0_cmd = mk(100, 100, 10, 10); r0_valid = 1'b1; #1;
    chk("s1_r0_ready", r0_ready, 1);
    chk("s1_r1_ready", r1_ready, 0);
    @(posedge clk); #1 r0_valid = 1'b0; #1;
    chk("s1_level1", fifo_level, 1);
    chk("s1_nostart", drw_start, 0);
    cyc();
    chk("s1_start", drw_start, 1);
    chk("s1_cmd", drw_cmd, mk(100, 100, 10, 10));
    cyc();
    chk("s1_start_pulse", drw_start, 0);
    chk("s1_busy", busy, 1);
    repeat (7) cyc();
    drw_done = 1'b1;
    @(posedge clk); #1 drw_done = 1'b0; #1;
    chk("s1_cmpv", cmp_valid, 1);
    chk("s1_src", cmp_src, 0);
    chk("s1_err", cmp_err, 0);
    cyc();
    chk("s1_idle_busy", busy, 0);
    chk("s1_cmpv_low", cmp_valid, 0);

    // Contention: both requesters always valid
    do_reset();
    r0_cmd = mk(1, 2, 3, 4); r1_cmd = mk(5, 6, 7, 8);
    r0_valid = 1'b1; r1_valid = 1'b1; #1;
    chk("s2_g0_r0", r0_ready, 1);
    chk("s2_g0_r1", r1_ready, 0);
    @(posedge clk); #1 r0_cmd = mk(9, 10, 11, 12); #1;
    chk("s2_g1_r0", r0_ready, 0);
    chk("s2_g1_r1", r1_ready, 1);
    @(posedge clk); #1 r1_cmd = mk(13, 14, 15, 16); #1;
    chk("s2_g2_r0", r0_ready, 1);
    chk("s2_g2_r1", r1_ready, 0);
    chk("s2_p0_start", drw_start, 1);
    chk("s2_p0_cmd", drw_cmd, mk(1, 2, 3, 4));
    @(posedge clk); #1 r0_cmd = mk(17, 18, 19, 20); #1;
    chk("s2_g3_r0", r0_ready, 0);
    chk("s2_g3_r1", r1_ready, 1);
    cyc();
    chk("s2_g4_r0", r0_ready, 1);
    chk("s2_g4_r1", r1_ready, 0);
    @(posedge clk); #1 r0_cmd = mk(21, 22, 23, 24); r1_cmd = mk(25, 26, 27, 28); #1;
    chk("s2_full_r0", r0_ready, 0);
    chk("s2_full_r1", r1_ready, 0);
    chk("s2_full_level", fifo_level, 4);
    @(posedge clk); #1 drw_done = 1'b1; #1;
    chk("s2_full_r1b", r1_ready, 0);
    @(posedge clk); #1 drw_done = 1'b0; r0_valid = 1'b0; r1_valid = 1'b0; #1;
    chk("s2_p0_cmpv", cmp_valid, 1);
    chk("s2_p0_src", cmp_src, 0);
    run_cmd("s2_q0", mk(5, 6, 7, 8), 1'b1);
    run_cmd("s2_p1", mk(9, 10, 11, 12), 1'b0);
    run_cmd("s2_q1", mk(13, 14, 15, 16), 1'b1);
    run_cmd("s2_p2", mk(17, 18, 19, 20), 1'b0);
    cyc();
    chk("s2_drained_level", fifo_level, 0);
    chk("s2_drained_busy", busy, 0);

    // Degenerate commands (a==0, then b==0) followed by a normal one
    do_reset();
    r0_cmd = mk(50, 50, 0, 7); r0_valid = 1'b1; #1;
    @(posedge clk); #1 r0_valid = 1'b0; r1_cmd = mk(70, 80, 3, 0); r1_valid = 1'b1; #1;
    chk("s3_e_ready", r1_ready, 1);
    @(posedge clk); #1 r1_valid = 1'b0; r0_cmd = mk(20, 30, 5, 6); r0_valid = 1'b1; #1;
    chk("s3_n_ready", r0_ready, 1);
    chk("s3_d_nostart", drw_start, 0);
    chk("s3_d_cmd", drw_cmd, mk(50, 50, 0, 7));
    @(posedge clk); #1 r0_valid = 1'b0; #1;
    chk("s3_d_cmpv", cmp_valid, 1);
    chk("s3_d_err", cmp_err, 2'b01);
    chk("s3_d_src", cmp_src, 0);
    cyc();
    cyc();
    chk("s3_e_nostart", drw_start, 0);
    chk("s3_e_cmd", drw_cmd, mk(70, 80, 3, 0));
    cyc();
    chk("s3_e_cmpv", cmp_valid, 1);
    chk("s3_e_err", cmp_err, 2'b01);
    chk("s3_e_src", cmp_src, 1);
    run_cmd("s3_n", mk(20, 30, 5, 6), 1'b0);

    // Timeout, then done coinciding with the final count
    do_reset();
    r1_cmd = mk(300, 200, 40, 30); r1_valid = 1'b1; #1;
    @(posedge clk); #1 r1_valid = 1'b0; r0_cmd = mk(10, 20, 30, 40); r0_valid = 1'b1; #1;
    chk("s4_t2_ready", r0_ready, 1);
    @(posedge clk); #1 r0_valid = 1'b0; #1;
    chk("s4_t1_start", drw_start, 1);
    chk("s4_t1_cmd", drw_cmd, mk(300, 200, 40, 30));
    repeat (16) cyc();
    chk("s4_t1_not_early", cmp_valid, 0);
    chk("s4_t1_busy", busy, 1);
    cyc();
    chk("s4_t1_cmpv", cmp_valid, 1);
    chk("s4_t1_err", cmp_err, 2'b10);
    chk("s4_t1_src", cmp_src, 1);
    cyc();
    chk("s4_pop_nostart", drw_start, 0);
    cyc();
    chk("s4_t2_start", drw_start, 1);
    chk("s4_t2_cmd", drw_cmd, mk(10, 20, 30, 40));
    repeat (16) cyc();
    drw_done = 1'b1;
    @(posedge clk); #1 drw_done = 1'b0; #1;
    chk("s4_t2_cmpv", cmp_valid, 1);
    chk("s4_t2_err", cmp_err, 2'b00);
    chk("s4_t2_src", cmp_src, 0);

    // Backpressure: drawer busy with one r0 command while r1 pushes five
    do_reset();
    for (int i = 0; i < 5; i++) bq[i] = mk(200 + i, 100 + i, 8 + i, 9 + i);
    r0_cmd = mk(400, 400, 100, 50); r0_valid = 1'b1; #1;
    @(posedge clk); #1 r0_valid = 1'b0; r1_cmd = bq[0]; r1_valid = 1'b1; #1;
    chk("s5_b0_ready", r1_ready, 1);
    @(posedge clk); #1 r1_cmd = bq[1]; #1;
    @(posedge clk); #1 r1_cmd = bq[2]; #1;
    @(posedge clk); #1 r1_cmd = bq[3]; #1;
    chk("s5_b3_ready", r1_ready, 1);
    @(posedge clk); #1 r1_cmd = bq[4]; #1;
    chk("s5_b4_held", r1_ready, 0);
    chk("s5_level4", fifo_level, 4);
    @(posedge clk); #1 drw_done = 1'b1; #1;
    chk("s5_b4_held2", r1_ready, 0);
    @(posedge clk); #1 drw_done = 1'b0; #1;
    chk("s5_h_cmpv", cmp_valid, 1);
    chk("s5_h_src", cmp_src, 0);
    chk("s5_b4_held3", r1_ready, 0);
    cyc();
    chk("s5_pop_held", r1_ready, 0);
    chk("s5_pop_level", fifo_level, 4);
    cyc();
    chk("s5_after_pop_level", fifo_level, 3);
    chk("s5_b4_accept", r1_ready, 1);
    chk("s5_b0_start", drw_start, 1);
    chk("s5_b0_cmd", drw_cmd, bq[0]);
    @(posedge clk); #1 r1_valid = 1'b0; #1;
    chk("s5_refill_level", fifo_level, 4);
    drw_done = 1'b1;
    @(posedge clk); #1 drw_done = 1'b0; #1;
    chk("s5_b0_cmpv", cmp_valid, 1);
    chk("s5_b0_src", cmp_src, 1);
    run_cmd("s5_b1", bq[1], 1'b1);
    run_cmd("s5_b2", bq[2], 1'b1);
    run_cmd("s5_b3", bq[3], 1'b1);
    run_cmd("s5_b4", bq[4], 1'b1);
    cyc();
    chk("s5_empty_level", fifo_level, 0);
    chk("s5_empty_busy", busy, 0);

    // Reset in mid-WAIT with commands queued, then a stray done
    do_reset();
    r0_cmd = mk(60, 60, 6, 6); r0_valid = 1'b1; #1;
    @(posedge clk); #1 r0_cmd = mk(61, 61, 6, 6); #1;
    @(posedge clk); #1 r0_cmd = mk(62, 62, 6, 6); #1;
    chk("s6_start", drw_start, 1);
    @(posedge clk); #1 r0_valid = 1'b0; #1;
    chk("s6_level2", fifo_level, 2);
    chk("s6_busy", busy, 1);
    @(posedge clk); #1 rst_ = 1'b1; r0_valid = 1'b1; #1;
    chk("s6_rst_ready", r0_ready, 0);
    chk("s6_rst_cmpv", cmp_valid, 0);
    chk("s6_rst_busy", busy, 0);
    @(posedge clk); #1 rst_ = 1'b0; r0_valid = 1'b0; drw_done = 1'b1; #1;
    chk("s6_post_level", fifo_level, 0);
    chk("s6_post_busy", busy, 0);
    chk("s6_post_cmd", drw_cmd, 0);
    chk("s6_post_cmpv", cmp_valid, 0);
    @(posedge clk); #1 drw_done = 1'b0; #1;
    chk("s6_stray_cmpv", cmp_valid, 0);
    chk("s6_stray_busy", busy, 0);
    cyc();
    chk("s6_stray_cmpv2", cmp_valid, 0);
    chk("s6_stray_start", drw_start, 0);

    // Reset landing on the CHECK cycle suppresses the start pulse
    r0_cmd = mk(90, 90, 9, 9); r0_valid = 1'b1; #1;
    @(posedge clk); #1 r0_valid = 1'b0; #1;
    @(posedge clk); #1 rst_ = 1'b1; #1;
    chk("s7_rst_nostart", drw_start, 0);
    @(posedge clk); #1 rst_ = 1'b0; #1;
    chk("s7_post_busy", busy, 0);
    cyc();
    chk("s7_post_nostart", drw_start, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", nassert, nfail);
    $finish;
  end

endmodule
